// File: rtl/decode_pipe_stage_if.sv
// Handshake/bus bundle for decode_pipe_stage: upstream valid/ready with
// instruction and PC, downstream valid/ready with decoded fields, flush,
// and the interlock bubble counter.
// Optional feature macro: DECODE_LOADUSE_INTERLOCK_EN (affects the stage only).
interface decode_pipe_stage_if #(
  parameter int OPC_W   = 4,
  parameter int REG_W   = 4,
  parameter int INSTR_W = 16,
  parameter int PC_W    = 8,
  parameter int CNT_W   = 8
);
  logic               i_valid;
  logic               o_ready;
  logic [INSTR_W-1:0] i_instruction;
  logic [PC_W-1:0]    i_pc;
  logic               i_flush;
  logic               o_valid;
  logic               i_ready;
  logic [OPC_W-1:0]   o_opcode;
  logic [REG_W-1:0]   o_srcadd_1;
  logic [REG_W-1:0]   o_srcadd_2;
  logic [REG_W-1:0]   o_destadd;
  logic [PC_W-1:0]    o_pc;
  logic [CNT_W-1:0]   o_bubble_cnt;

  // Environment side: drives instructions and downstream ready.
  modport master (
    output i_valid, i_instruction, i_pc, i_flush, i_ready,
    input  o_ready, o_valid, o_opcode, o_srcadd_1, o_srcadd_2, o_destadd,
           o_pc, o_bubble_cnt
  );

  // Decode stage side.
  modport slave (
    input  i_valid, i_instruction, i_pc, i_flush, i_ready,
    output o_ready, o_valid, o_opcode, o_srcadd_1, o_srcadd_2, o_destadd,
           o_pc, o_bubble_cnt
  );
endinterface

// File: rtl/decode_pipe_stage.sv
// Registered instruction-decode stage with a 2-entry (head + skid) buffer.
// Head drives the decoded fields; skid catches one extra instruction so
// o_ready can come purely from registered state.
// Optional feature macro: DECODE_LOADUSE_INTERLOCK_EN -- inserts one bubble
// when the instruction right after a load reads the load's destination.
module decode_pipe_stage #(
  parameter int              OPC_W    = 4,
  parameter int              REG_W    = 4,
  parameter int              INSTR_W  = 16,
  parameter int              PC_W     = 8,
  parameter logic [OPC_W-1:0] LOAD_OPC = 4'hA,
  parameter int              CNT_W    = 8
) (
  input logic               i_clk,
  input logic               i_rst,
  decode_pipe_stage_if.slave bus
);

  // Field layout must tile the instruction word exactly.
  if ((INSTR_W != OPC_W + 3*REG_W) || ($bits(LOAD_OPC) != OPC_W)) begin : g_bad_cfg
    $error("decode_pipe_stage: INSTR_W must equal OPC_W + 3*REG_W");
  end

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  entry_t           head, skid, in_entry;
  logic             head_valid, skid_valid;
  logic             accept, issue, bubble;
  logic [OPC_W-1:0] opc;
  logic [REG_W-1:0] src1, src2, dest;

  assign in_entry = '{instr: bus.i_instruction, pc: bus.i_pc};

  // Raw field slices of the head entry.
  assign opc  = head.instr[INSTR_W-1 -: OPC_W];
  assign src1 = head.instr[INSTR_W-OPC_W-1 -: REG_W];
  assign src2 = head.instr[INSTR_W-OPC_W-REG_W-1 -: REG_W];
  assign dest = head.instr[REG_W-1:0];

  // Ready depends only on skid occupancy and reset, never on i_ready.
  assign bus.o_ready = !skid_valid && !i_rst;
  assign accept      = bus.i_valid && bus.o_ready;
  assign bus.o_valid = head_valid && !bubble;
  assign issue       = bus.o_valid && bus.i_ready;

  // Fields read as zero whenever the head holds nothing.
  assign bus.o_opcode   = opc  & {OPC_W{head_valid}};
  assign bus.o_srcadd_1 = src1 & {REG_W{head_valid}};
  assign bus.o_srcadd_2 = src2 & {REG_W{head_valid}};
  assign bus.o_destadd  = dest & {REG_W{head_valid}};
  assign bus.o_pc       = head.pc & {PC_W{head_valid}};

`ifdef DECODE_LOADUSE_INTERLOCK_EN
  logic             ld_pending;
  logic [REG_W-1:0] ld_dest;
  logic [CNT_W-1:0] bubble_cnt;

  // One-cycle hazard window after a load issues; register 0 is not special.
  assign bubble = ld_pending && head_valid && ((src1 == ld_dest) || (src2 == ld_dest));
  assign bus.o_bubble_cnt = bubble_cnt;

  // Interlock state: remember the last issued load; count bubbles (flush keeps the count).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ld_pending <= 1'b0;
      ld_dest    <= '0;
      bubble_cnt <= '0;
    end else begin
      if (bubble && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + 1'b1;
      if (bus.i_flush) begin
        ld_pending <= 1'b0;
      end else begin
        ld_pending <= issue && (opc == LOAD_OPC);
        if (issue) ld_dest <= dest;
      end
    end
  end
`else
  assign bubble           = 1'b0;
  assign bus.o_bubble_cnt = '0;
`endif

  // Head/skid buffer: reset > flush > issue/accept; program order kept by
  // always refilling the head from the skid before taking new input.
  always_ff @(posedge i_clk) begin
    if (i_rst || bus.i_flush) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      head       <= '0;
      skid       <= '0;
    end else if (issue) begin
      if (skid_valid) begin
        head       <= skid;
        skid_valid <= accept;
        if (accept) skid <= in_entry;
      end else if (accept) begin
        head <= in_entry;
      end else begin
        head_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!head_valid) begin
        head       <= in_entry;
        head_valid <= 1'b1;
      end else begin
        skid       <= in_entry;
        skid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Bench for decode_pipe_stage: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the stage.
module tb_decode_pipe_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_pipe_stage_if bus ();
  decode_pipe_stage dut (.i_clk(clk), .i_rst(rst), .bus(bus));

`ifdef DECODE_LOADUSE_INTERLOCK_EN
  localparam bit IL = 1'b1;
`else
  localparam bit IL = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: queue of held {instr, pc}, pending-load flag, bubble count.
  logic [23:0] q[$];
  bit          m_pend;
  logic [3:0]  m_dest;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle, check all outputs, then advance the model.
  task automatic step(input bit r, input bit v, input logic [15:0] ins,
                      input logic [7:0] pc, input bit fl, input bit rd);
    bit hv, bub, ev, er, iss, acc;
    logic [15:0] hi;
    logic [7:0]  hp;
    rst = r; bus.i_valid = v; bus.i_instruction = ins; bus.i_pc = pc;
    bus.i_flush = fl; bus.i_ready = rd;
    #1;
    hv  = q.size() > 0;
    hi  = hv ? q[0][23:8] : 16'h0;
    hp  = hv ? q[0][7:0]  : 8'h0;
    bub = IL && m_pend && hv && ((hi[11:8] == m_dest) || (hi[7:4] == m_dest));
    ev  = hv && !bub;
    er  = !r && (q.size() < 2);
    chk("o_valid", bus.o_valid, ev);
    chk("o_ready", bus.o_ready, er);
    chk("o_opcode", bus.o_opcode, hi[15:12]);
    chk("o_srcadd_1", bus.o_srcadd_1, hi[11:8]);
    chk("o_srcadd_2", bus.o_srcadd_2, hi[7:4]);
    chk("o_destadd", bus.o_destadd, hi[3:0]);
    chk("o_pc", bus.o_pc, hp);
    chk("o_bubble_cnt", bus.o_bubble_cnt, m_cnt);
    @(posedge clk);
    if (r) begin
      q.delete(); m_pend = 0; m_cnt = 0;
    end else begin
      if (bub && m_cnt < 255) m_cnt++;
      if (fl) begin
        q.delete(); m_pend = 0;
      end else begin
        iss = ev && rd;
        acc = v && er;
        if (iss) begin
          m_pend = (hi[15:12] == 4'hA);
          m_dest = hi[3:0];
          void'(q.pop_front());
        end else begin
          m_pend = 0;
        end
        if (acc) q.push_back({ins, pc});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] ins;
    rst = 1'b1; bus.i_valid = 0; bus.i_instruction = '0; bus.i_pc = '0;
    bus.i_flush = 0; bus.i_ready = 0;
    q.delete(); m_pend = 0; m_dest = '0; m_cnt = 0;
    @(posedge clk); @(negedge clk);

    // Reset with an instruction offered: nothing accepted, ready low.
    step(1, 1, 16'h1234, 8'h00, 0, 1);
    step(1, 1, 16'h1234, 8'h00, 0, 1);
    step(0, 0, 16'h0000, 8'h00, 0, 1);
    chk("ready_after_rst", bus.o_ready, 1);
    chk("valid_after_rst", bus.o_valid, 0);

    // Back-to-back streaming.
    step(0, 1, 16'h1234, 8'h00, 0, 1);
    chk("s0_opc", bus.o_opcode, 4'h1); chk("s0_s1", bus.o_srcadd_1, 4'h2);
    chk("s0_s2", bus.o_srcadd_2, 4'h3); chk("s0_dst", bus.o_destadd, 4'h4);
    step(0, 1, 16'h5678, 8'h01, 0, 1);
    chk("s1_opc", bus.o_opcode, 4'h5); chk("s1_dst", bus.o_destadd, 4'h8);
    chk("s1_pc", bus.o_pc, 8'h01); chk("s1_valid", bus.o_valid, 1);
    step(0, 0, 16'h0, 8'h0, 0, 1);
    step(0, 0, 16'h0, 8'h0, 0, 1);

    // Backpressure: two accepted, third held upstream until space frees.
    step(0, 1, 16'h1111, 8'h10, 0, 0);
    step(0, 1, 16'h2222, 8'h11, 0, 0);
    chk("bp_ready_low", bus.o_ready, 0);
    step(0, 1, 16'h3333, 8'h12, 0, 0);
    step(0, 1, 16'h3333, 8'h12, 0, 0);
    step(0, 1, 16'h3333, 8'h12, 0, 1);
    chk("bp_second", bus.o_opcode, 4'h2);
    step(0, 1, 16'h3333, 8'h12, 0, 1);
    chk("bp_third", bus.o_opcode, 4'h3);
    step(0, 0, 16'h0, 8'h0, 0, 1);
    step(0, 0, 16'h0, 8'h0, 0, 1);

    // Flush with both entries held and a new instruction offered.
    step(0, 1, 16'h5555, 8'h20, 0, 0);
    step(0, 1, 16'h6666, 8'h21, 0, 0);
    step(0, 1, 16'h4444, 8'h22, 1, 0);
    chk("fl_valid", bus.o_valid, 0);
    chk("fl_ready", bus.o_ready, 1);
    step(0, 0, 16'h0, 8'h0, 0, 1);
    step(0, 0, 16'h0, 8'h0, 1, 1);   // flush while empty
    step(0, 0, 16'h0, 8'h0, 0, 1);

    // Load followed by a dependent instruction, then an independent one.
    step(0, 1, 16'hA123, 8'h30, 0, 1);
    step(0, 1, 16'h1345, 8'h31, 0, 1);
    step(0, 0, 16'h0, 8'h0, 0, 1);
    step(0, 0, 16'h0, 8'h0, 0, 1);
    step(0, 0, 16'h0, 8'h0, 0, 1);
    chk("lu_cnt_dep", bus.o_bubble_cnt, 32'(IL));
    step(0, 1, 16'hA123, 8'h32, 0, 1);
    step(0, 1, 16'h1456, 8'h33, 0, 1);
    chk("lu_nodep_valid", bus.o_valid, 1);
    step(0, 0, 16'h0, 8'h0, 0, 1);
    step(0, 0, 16'h0, 8'h0, 0, 1);
    chk("lu_cnt_nodep", bus.o_bubble_cnt, 32'(IL));

    // Random traffic: small register range and frequent loads to provoke hazards.
    for (int i = 0; i < 500; i++) begin
      ins[15:12] = ($urandom_range(0, 2) == 0) ? 4'hA : 4'($urandom);
      ins[11:8]  = 4'($urandom_range(0, 3));
      ins[7:4]   = 4'($urandom_range(0, 3));
      ins[3:0]   = 4'($urandom_range(0, 3));
      step($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, ins,
           8'($urandom), $urandom_range(0, 30) == 0, $urandom_range(0, 2) != 0);
    end

    // Final reset clears the bubble count.
    step(1, 1, 16'hA111, 8'h0, 0, 1);
    step(0, 0, 16'h0, 8'h0, 0, 1);
    chk("final_cnt", bus.o_bubble_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/decode_pipe_stage.md
Name: decode_pipe_stage

Overview:
- Registered, parametrised instruction-decode stage sitting between the fetch latch and the register-file read/execute stage.
- Splits each instruction into opcode, source-1, source-2 and destination fields.
- Carries a PC tag alongside each instruction.
- Uses valid/ready handshakes on both sides with a 2-entry skid buffer, so throughput is one instruction per cycle under backpressure.
- Supports pipeline flush and an optional load-use interlock.

Parameters:
- OPC_W, 4: opcode field width
- REG_W, 4: register address field width
- INSTR_W, 16: instruction width; must equal OPC_W + 3*REG_W (elaboration error otherwise)
- PC_W, 8: width of the PC tag carried with each instruction
- LOAD_OPC, 4'hA: opcode value treated as a load by the interlock
- CNT_W, 8: bubble counter width (used only with the optional feature)

Ports:
- i_clk  in  1  clock; all state changes on its rising edge
- i_rst  in  1  synchronous reset, active-high
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage can accept an instruction
- i_instruction  in  INSTR_W  instruction word
- i_pc  in  PC_W  PC tag of i_instruction
- i_flush  in  1  discard all held instructions
- o_valid  out  1  decoded instruction valid
- i_ready  in  1  downstream accepts
- o_opcode  out  OPC_W  bits [INSTR_W-1 -: OPC_W]
- o_srcadd_1  out  REG_W  next REG_W bits below the opcode
- o_srcadd_2  out  REG_W  next REG_W bits below source-1
- o_destadd  out  REG_W  bits [REG_W-1:0]
- o_pc  out  PC_W  PC tag of the presented instruction
- o_bubble_cnt  out  CNT_W  interlock bubble count (0 when the feature is absent)

Behaviour:
- Reset:
  - i_rst high at an edge empties both entries and clears the interlock state.
  - Next-cycle values: o_valid=0; o_opcode, o_srcadd_1, o_srcadd_2, o_destadd, o_pc = 0; o_bubble_cnt=0.
  - o_ready is forced 0 while i_rst is high.
  - Reset mid-stream drops all held instructions; nothing is presented afterwards.
- Storage:
  - Head register drives the outputs; skid register holds one extra instruction.
  - o_ready = !skid_valid and !i_rst, derived from registered state only, with no combinational path from i_ready.
- Accept:
  - i_valid && o_ready at an edge captures the instruction.
  - If the head is empty, or the head is issuing and the skid is empty, the new instruction goes to the head.
  - Otherwise it goes to the skid.
  - When the head issues and the skid is full, the skid moves to the head. A simultaneous accept then loads the skid.
- Issue: o_valid && i_ready at an edge. Program order is always preserved.
- Latency and throughput:
  - Latency is 1 cycle: an instruction accepted at edge N is presented (o_valid=1) after edge N.
  - Sustained rate is 1 per cycle when i_ready=1.
- Output stability: while o_valid=1 and i_ready=0, all o_* fields hold stable.
- Flush:
  - i_flush high at an edge empties both entries and clears the interlock state.
  - Any instruction offered in the same cycle is discarded even if o_ready=1.
  - Priority order: i_rst > i_flush > accept/issue.
  - Flush while empty has no effect.
- Field extraction:
  - Combinational from the head register; no arithmetic.
  - Fields are zero when the head is empty.

Optional Feature:
- Macro: DECODE_LOADUSE_INTERLOCK_EN.
- With the macro defined:
  - On issue of an instruction with opcode == LOAD_OPC, set ld_pending=1 and ld_dest=that o_destadd.
  - ld_pending is cleared at any edge with no load issue.
  - In the cycle after the load issues, if the head is valid and o_srcadd_1==ld_dest or o_srcadd_2==ld_dest, o_valid is forced 0 (a bubble) and the head holds.
  - The bubble clears ld_pending, so exactly one bubble is inserted.
  - Register 0 is compared like any other register.
  - Each bubble increments o_bubble_cnt, saturating at all-ones. It is cleared by reset only, not by flush.
- Without the macro: no interlock logic is present, o_valid = head_valid, and o_bubble_cnt is tied to 0.

Test Plan:
- Reset:
  - Stimulus: drive i_valid=1 with i_instruction=16'h1234 while i_rst=1 for 2 cycles, then release reset.
  - Required: o_valid=0, all fields 0, o_ready=0 during reset; o_ready=1 the cycle after release; nothing is presented.
- Streaming:
  - Stimulus: i_ready=1; send 16'h1234 (pc 8'h00) then 16'h5678 (pc 8'h01) back-to-back.
  - Required: 1 cycle later opcode=1, src1=2, src2=3, dest=4, pc=00; the next cycle opcode=5, src1=6, src2=7, dest=8, pc=01; no gaps.
- Backpressure:
  - Stimulus: i_ready=0; offer 16'h1111, 16'h2222, 16'h3333 continuously.
  - Required: first two accepted; o_ready=0 afterwards; 16'h3333 held upstream.
  - Then raise i_ready: issue order is 1111, 2222, 3333, one per cycle.
- Flush:
  - Stimulus: with 2 entries held (i_ready=0), assert i_flush for 1 cycle together with i_valid=1 and instruction 16'h4444.
  - Required: next cycle o_valid=0, o_ready=1; 16'h4444 never appears.
- Load-use (macro defined):
  - Stimulus: i_ready=1; issue 16'hA123 then 16'h1345.
  - Required: o_valid=0 for exactly one cycle between them; 16'h1345 is then issued; o_bubble_cnt=1.
  - Stimulus: 16'hA123 then 16'h1456 (no dependency).
  - Required: no bubble.
- Load-use (macro undefined):
  - Stimulus: 16'hA123 then 16'h1345.
  - Required: back-to-back issue; o_bubble_cnt stays 0.
